// File: rtl/counter_arb_pkg.sv
// counter_arb_pkg: shared types, defaults and helpers for the counter_arbiter
// block and its interval_counter sub-module.
// Build option: define COUNTER_ARB_RR_EN for round-robin arbitration,
// otherwise the arbiter is fixed priority (lowest index wins).
package counter_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 4;
    localparam int MAX_REQ   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } arbState_e;

    // One-hot encode a requester index into the widest supported grant vector;
    // callers cast the result down to their own requester count.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/counter_arbiter_counter.sv
// interval_counter: the shared run counter. Clear wins over enable, and the
// count wraps modulo 2^CNT_W with no carry out.
module interval_counter
    import counter_arb_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    // Count register: synchronous reset, then clear, then increment when enabled.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one interval counter among N_REQ requesters.
// A grant latches the winner's run length, the counter runs for that many
// cycles (0 means a full 2^CNT_W), then the owner gets a one-cycle done pulse.
// Build option: COUNTER_ARB_RR_EN selects a round-robin priority pointer;
// without it the lowest requesting index always wins and no pointer exists.
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   len,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [CNT_W-1:0]         count
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arbState_e        state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [CNT_W-1:0] lenLat_q, lenLat_d;
    logic [CNT_W-1:0] cntVal;
    logic             anyReq;
    logic             runEnd;
    logic             cntClear;
    logic             cntEnable;
    logic [N_REQ-1:0] reqRot;
    logic [IDX_W-1:0] offIdx;
    logic [IDX_W-1:0] winIdx;
    logic [CNT_W-1:0] lenArr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : gLen
        assign lenArr[g] = len[g*CNT_W +: CNT_W];
    end

    assign anyReq = |req;

`ifdef COUNTER_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   winSum;
    logic [IDX_W:0]   ptrSum;

    // Rotate the request vector so the highest-priority index lands at bit 0.
    always_comb begin
        reqRot = N_REQ'({req, req} >> ptr_q);
    end

    // Map the rotated offset back to a requester index and advance the pointer past it on a grant.
    always_comb begin
        winSum = {1'b0, ptr_q} + {1'b0, offIdx};
        if (winSum >= (IDX_W+1)'(N_REQ)) begin
            winSum = winSum - (IDX_W+1)'(N_REQ);
        end
        winIdx = winSum[IDX_W-1:0];
        ptrSum = {1'b0, winIdx} + (IDX_W+1)'(1);
        if (ptrSum == (IDX_W+1)'(N_REQ)) begin
            ptrSum = '0;
        end
        ptr_d = ptr_q;
        if ((state_q == IDLE) && anyReq) begin
            ptr_d = ptrSum[IDX_W-1:0];
        end
    end

    // Priority pointer register.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: requests are used unrotated, so the offset is the winner.
    always_comb begin
        reqRot = req;
    end

    assign winIdx = offIdx;
`endif

    // Priority pick: lowest set bit of the (possibly rotated) request vector.
    always_comb begin
        offIdx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (reqRot[k]) begin
                offIdx = k[IDX_W-1:0];
            end
        end
    end

    // A latched length of 0 compares against all-ones, giving a full 2^CNT_W run.
    assign runEnd = (cntVal == (lenLat_q - CNT_W'(1)));

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; arbitration only ever starts from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (anyReq) state_d = RUN;
            RUN:     if (runEnd) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: next grant/done values, length latch and counter controls.
    always_comb begin
        gnt_d     = gnt_q;
        done_d    = '0;
        lenLat_d  = lenLat_q;
        cntClear  = 1'b0;
        cntEnable = 1'b0;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    gnt_d    = N_REQ'(onehot(3'(winIdx)));
                    lenLat_d = lenArr[winIdx];
                    cntClear = 1'b1;
                end else begin
                    gnt_d = '0;
                end
            end
            RUN: begin
                if (runEnd) begin
                    gnt_d  = '0;
                    done_d = gnt_q;
                end else begin
                    cntEnable = 1'b1;
                end
            end
            DONE:    gnt_d = '0;
            default: gnt_d = '0;
        endcase
    end

    // Registered grant, done pulse and latched run length.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            gnt_q    <= '0;
            done_q   <= '0;
            lenLat_q <= '0;
        end else begin
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            lenLat_q <= lenLat_d;
        end
    end

    interval_counter #(
        .CNT_W (CNT_W)
    ) uCounter (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .clear_i  (cntClear),
        .enable_i (cntEnable),
        .count_o  (cntVal)
    );

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);
    assign count = cntVal;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: directed bench for counter_arbiter with a job scoreboard.
// Expected grants follow COUNTER_ARB_RR_EN when it is defined for the build.
module tb_counter_arbiter;

    localparam int NR = 4;
    localparam int CW = 4;

    typedef struct {
        logic [NR-1:0] gnt;
        int            cycles;
    } job_t;

    logic             CLK = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    req;
    logic [NR*CW-1:0] len;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    done;
    logic             busy;
    logic [CW-1:0]    count;

    int   errors  = 0;
    int   checks  = 0;
    int   cycleNo = 0;
    job_t sbQ[$];

    counter_arbiter #(
        .N_REQ (NR),
        .CNT_W (CW)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .req     (req),
        .len     (len),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .count   (count)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Edge counter used to measure job spacing.
    always @(posedge CLK) cycleNo <= cycleNo + 1;

    // Global watchdog so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] reqV, input logic [NR*CW-1:0] lenV);
        req = reqV;
        len = lenV;
    endtask

    task automatic expectJob(input logic [NR-1:0] gntV, input int cycles);
        job_t j;
        j.gnt    = gntV;
        j.cycles = cycles;
        sbQ.push_back(j);
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    // Wait for a grant, compare it with the next scoreboard entry, follow the run
    // through its done pulse and return to IDLE. releaseAt < 0 keeps req held.
    task automatic serveJob(input int releaseAt, output int grantCycle);
        job_t j;
        int   guard;
        int   cyc;
        guard = 0;
        while (gnt == '0 && guard < 40) begin
            stepCycle();
            guard++;
        end
        grantCycle = cycleNo;
        if (sbQ.size() == 0) begin
            j.gnt    = '0;
            j.cycles = 0;
        end else begin
            j = sbQ.pop_front();
        end
        cyc = 0;
        while (gnt != '0 && cyc < 40) begin
            checkOutput("gntOwner", 32'(gnt), 32'(j.gnt));
            checkOutput("runCount", 32'(count), cyc % 16);
            checkOutput("runBusy", 32'(busy), 1);
            checkOutput("runDone", 32'(done), 0);
            if (cyc == releaseAt) req = req & ~j.gnt;
            stepCycle();
            cyc++;
        end
        checkOutput("gntWidth", cyc, j.cycles);
        checkOutput("donePulse", 32'(done), 32'(j.gnt));
        checkOutput("doneBusy", 32'(busy), 1);
        checkOutput("countHold", 32'(count), (j.cycles - 1) % 16);
        stepCycle();
        checkOutput("doneClear", 32'(done), 0);
        checkOutput("idleBusy", 32'(busy), 0);
    endtask

    initial begin
        int   gc;
        int   prevGrant;
        job_t j;

        // Reset held with every requester asking.
        reset_n = 1'b0;
        applyStimulus(4'b1111, 16'h1111);
        repeat (3) begin
            stepCycle();
            checkOutput("rstGnt", 32'(gnt), 0);
            checkOutput("rstDone", 32'(done), 0);
            checkOutput("rstBusy", 32'(busy), 0);
            checkOutput("rstCount", 32'(count), 0);
        end

        // All requesters held high with len 1: grant order and 3-cycle spacing.
        reset_n = 1'b1;
`ifdef COUNTER_ARB_RR_EN
        expectJob(4'b0001, 1);
        expectJob(4'b0010, 1);
        expectJob(4'b0100, 1);
        expectJob(4'b1000, 1);
        expectJob(4'b0001, 1);
`else
        repeat (5) expectJob(4'b0001, 1);
`endif
        prevGrant = 0;
        for (int n = 0; n < 5; n++) begin
            serveJob(-1, gc);
            if (n > 0) checkOutput("spacing", gc - prevGrant, 3);
            prevGrant = gc;
        end
        applyStimulus(4'b0000, 16'h1111);

        // Single requester 2 with len 5; other len fields hold junk.
        applyStimulus(4'b0100, 16'h0503);
        expectJob(4'b0100, 5);
        serveJob(0, gc);

        // len 0 means a full 16-cycle run with the count wrapping to 15.
        applyStimulus(4'b0001, 16'hFFF0);
        expectJob(4'b0001, 16);
        serveJob(0, gc);

        // Requester 1 drops req mid-run: the job still completes, no re-grant.
        applyStimulus(4'b0010, 16'h0060);
        expectJob(4'b0010, 6);
        serveJob(3, gc);
        repeat (3) begin
            stepCycle();
            checkOutput("noRegrant", 32'(gnt), 0);
            checkOutput("noRegrantBusy", 32'(busy), 0);
        end

        // Reset in RUN cycle 3 of a len 8 job drops it without a done pulse.
        applyStimulus(4'b1000, 16'h8000);
        expectJob(4'b1000, 8);
        stepCycle();
        j = sbQ.pop_front();
        checkOutput("abortGrant", 32'(gnt), 32'(j.gnt));
        req = '0;
        stepCycle();
        stepCycle();
        checkOutput("abortPreCount", 32'(count), 2);
        reset_n = 1'b0;
        stepCycle();
        checkOutput("abortGnt", 32'(gnt), 0);
        checkOutput("abortBusy", 32'(busy), 0);
        checkOutput("abortCount", 32'(count), 0);
        checkOutput("abortDone", 32'(done), 0);
        reset_n = 1'b1;
        repeat (3) begin
            stepCycle();
            checkOutput("abortNoDone", 32'(done), 0);
            checkOutput("abortIdleGnt", 32'(gnt), 0);
        end

        checkOutput("sbEmpty", sbQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Shares one CNT_W-bit interval counter among N_REQ requesters. Each requester asks for a run of a given length. A round-robin arbiter grants the counter to one requester at a time. The counter runs for exactly that many cycles, then the block returns a one-cycle completion pulse to the owner. It sits between the lab's requesting FSMs and the shared counter datapath, and replaces ad-hoc private counters.

## Interface
- N_REQ, default 4: number of requesters (2..8).
- CNT_W, default 4: counter width; maximum run is 2^CNT_W cycles.
- CLK, input, 1: clock; all state updates on the rising edge.
- reset_n, input, 1: reset, synchronous, active-low; sampled on the CLK rising edge.
- req, input, N_REQ: request level per requester; must stay high until that requester's gnt bit rises.
- len, input, N_REQ*CNT_W: run length per requester; requester i uses bits [i*CNT_W +: CNT_W]. Sampled only at grant.
- gnt, output, N_REQ: one-hot (or zero) owner of the counter; registered.
- done, output, N_REQ: one-cycle completion pulse to the owner; registered.
- busy, output, 1: high whenever state is not IDLE.
- count, output, CNT_W: elapsed run cycles minus one; mirrors the shared counter.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - If any req bit is high at an edge, the arbiter picks winner w, latches len[w] and moves to RUN.
  - At the same edge: gnt <= onehot(w), count <= 0.
  - If no req bit is high, stay in IDLE.
- RUN:
  - count increments by 1 each edge.
  - At the edge where count == len_latched - 1 (mod 2^CNT_W): gnt <= 0, done[w] <= 1, count holds, state <= DONE.
- DONE: for one cycle, at the next edge done <= 0 and state <= IDLE. Arbitration happens only in IDLE.
- Run length:
  - len = L with 1 <= L <= 2^CNT_W-1 gives gnt high for exactly L cycles.
  - len = 0 means 2^CNT_W cycles (16 at default); the terminal compare wraps to all-ones.
- Count arithmetic is modulo 2^CNT_W. No carry out and no overflow flag.
- Requests during RUN/DONE:
  - They are not arbitrated, and a req deassert during RUN does not abort the job.
  - A req still high in IDLE after done is treated as a new job.
- Arbitration:
  - Priority pointer resets to 0.
  - After a grant to w, index (w+1) mod N_REQ has highest priority, then ascending with wrap.
- Reset values: state IDLE, gnt 0, done 0, busy 0, count 0, pointer 0, latched len 0.
- Reset mid-run: at the edge with reset_n low, all of the above reset and the current job is dropped. No done pulse is issued for it.
- len bits of non-winning requesters are ignored.

## Timing
- Request-to-grant latency is 1 cycle: req high before edge E in IDLE gives gnt high after E.
- gnt width is L cycles. done rises at the same edge gnt falls and is high for 1 cycle.
- Minimum back-to-back spacing is len + 2 cycles per job (RUN L, DONE 1, IDLE arbitration 1).
- busy is high from the grant edge through the DONE cycle, i.e. L + 1 cycles.
- All outputs are registered. There is no combinational path from req or len to any output.

## Configuration
- Macro: COUNTER_ARB_RR_EN.
- Defined: round-robin pointer as described under Operation.
- Undefined: fixed priority, lowest index wins. The pointer logic is omitted and there is no pointer register.
- All other behaviour is identical in both builds.

## Structure
- Package counter_arb_pkg holds:
  - state typedef: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  - default N_REQ / CNT_W localparams;
  - the onehot helper function.
- Sub-module interval_counter:
  - CNT_W-bit counter with synchronous clear, enable and active-low synchronous reset_n;
  - instantiated once;
  - the FSM drives clear at grant and enable in RUN.
- The arbiter (priority pick plus pointer) stays inline in counter_arbiter.

## Test plan
- Reset with req = 4'b1111 and reset_n low for 3 cycles → gnt = 0, done = 0, busy = 0, count = 0 throughout.
- req[2] = 1 with len[2] = 5 → gnt = 4'b0100 one cycle later, high 5 cycles, count 0→4; done = 4'b0100 for 1 cycle as gnt falls; busy high 6 cycles.
- len[0] = 0 with req[0] = 1 → gnt[0] high 16 cycles, count wraps to 15, then a done[0] pulse.
- req = 4'b1111 held, all len = 1 → with COUNTER_ARB_RR_EN grants go 0, 1, 2, 3, 0, one job every 3 cycles; without it, requester 0 wins every time.
- req[1] dropped mid-run with len[1] = 6 → run completes, done[1] pulses, no re-grant to requester 1.
- reset_n low at RUN cycle 3 of a len = 8 job → next cycle state IDLE, gnt = 0, count = 0, no done pulse.
